block_memory_retrieval: RTL and testbench

Read-side companion to the SSID hit storage block. It accepts one SSID query at a time and walks the three block memories in order: HNM (hit flag), HCM (count plus HLM address), then HLM (packed hit info). It then streams the stored hit words out one per beat under valid/ready flow control. It drives the port-A read side of the three memories, which the storage block leaves free, and it never writes memory.

---
 rtl/block_memory_retrieval.sv | 150 +++++++++++++++
 tb/tb_block_memory_retrieval.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_memory_retrieval.sv
// Read-side companion to the SSID hit storage: walks HNM, HCM and HLM
// on port A for one queried SSID, then streams its stored hit words.
//
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   storageReady          low while the storage block clears or writes
//   requestValid/Ready    query handshake, requestSSID is the query
//   hnmAddress/hnmData    HNM port-A read (row address, hit-flag row)
//   hcmAddress/hcmData    HCM port-A read ({HLM address, count})
//   hlmAddress/hlmData    HLM port-A read (packed hit slots)
//   hitValid/hitReady     output beat handshake
//   hitInfo               hit word, oldest first
//   hitLast               final beat of the query
//   hitEmpty              beat carries no hit (miss, zero count, abort)

module block_memory_retrieval #(
   parameter int SSIDBITS         = 12,
   parameter int COLINDEXBITS_HNM = 4,
   parameter int ROWINDEXBITS_HNM = 8,
   parameter int ROWINDEXBITS_HLM = 8,
   parameter int MAXHITNBITS      = 3,
   parameter int NCOLS_HCM        = 11,
   parameter int HITINFOBITS      = 8,
   parameter int NCOLS_HLM        = 56
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        storageReady,
   input  logic                        requestValid,
   output logic                        requestReady,
   input  logic [SSIDBITS-1:0]         requestSSID,
   output logic [ROWINDEXBITS_HNM-1:0] hnmAddress,
   input  logic [(2**COLINDEXBITS_HNM)-1:0] hnmData,
   output logic [SSIDBITS-1:0]         hcmAddress,
   input  logic [NCOLS_HCM-1:0]        hcmData,
   output logic [ROWINDEXBITS_HLM-1:0] hlmAddress,
   input  logic [NCOLS_HLM-1:0]        hlmData,
   output logic                        hitValid,
   input  logic                        hitReady,
   output logic [HITINFOBITS-1:0]      hitInfo,
   output logic                        hitLast,
   output logic                        hitEmpty
);

   localparam int NSLOTS = NCOLS_HLM / HITINFOBITS;
   localparam logic [MAXHITNBITS-1:0] MAXN = MAXHITNBITS'(NSLOTS);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CHECK,
      HLM_READ,
      HLM_LOAD,
      EMIT,
      EMPTY
   } state_t;

   state_t state, nextState;

   logic [COLINDEXBITS_HNM-1:0] column;
   logic [MAXHITNBITS-1:0]      hitCount;
   logic [MAXHITNBITS-1:0]      slot;
   logic [NCOLS_HLM-1:0]        hitWord;

   logic                        accept;
   logic                        hnmBit;
   logic [MAXHITNBITS-1:0]      hcmCount;
   logic [MAXHITNBITS-1:0]      clampedCount;
   logic [ROWINDEXBITS_HLM-1:0] hcmHlmAddress;

   assign accept        = requestValid && requestReady;
   assign hnmBit        = hnmData[column];
   assign hcmCount      = hcmData[MAXHITNBITS-1:0];
   assign hcmHlmAddress = hcmData[MAXHITNBITS +: ROWINDEXBITS_HLM];
   assign clampedCount  = (hcmCount > MAXN) ? MAXN : hcmCount;

   always_comb begin
      nextState    = state;
      requestReady = 1'b0;
      hitValid     = 1'b0;
      hitInfo      = '0;
      hitLast      = 1'b0;
      hitEmpty     = 1'b0;
      unique case (state)
         IDLE: begin
            requestReady = storageReady && !reset;
            if (accept) nextState = READ;
         end
         READ:
            nextState = storageReady ? CHECK : EMPTY;
         CHECK: begin
            if (!storageReady || !hnmBit || hcmCount == '0)
               nextState = EMPTY;
            else
               nextState = HLM_READ;
         end
         HLM_READ:
            nextState = storageReady ? HLM_LOAD : EMPTY;
         HLM_LOAD:
            nextState = storageReady ? EMIT : EMPTY;
         EMIT: begin
            hitValid = 1'b1;
            hitInfo  = hitWord[slot*HITINFOBITS +: HITINFOBITS];
            hitLast  = (slot == '0);
            if (hitReady && slot == '0) nextState = IDLE;
         end
         EMPTY: begin
            hitValid = 1'b1;
            hitEmpty = 1'b1;
            hitLast  = 1'b1;
            if (hitReady) nextState = IDLE;
         end
         default:
            nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         column     <= '0;
         hnmAddress <= '0;
         hcmAddress <= '0;
         hlmAddress <= '0;
         hitCount   <= '0;
         slot       <= '0;
         hitWord    <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE && accept) begin
            column     <= requestSSID[COLINDEXBITS_HNM-1:0];
            hnmAddress <= requestSSID[SSIDBITS-1 -: ROWINDEXBITS_HNM];
            hcmAddress <= requestSSID;
         end
         if (state == CHECK && nextState == HLM_READ) begin
            hlmAddress <= hcmHlmAddress;
            hitCount   <= clampedCount;
         end
         // Slot 0 is the newest hit, so start from the highest
         // occupied slot to emit oldest first.
         if (state == HLM_LOAD) begin
            hitWord <= hlmData;
            slot    <= hitCount - 1'b1;
         end
         if (state == EMIT && hitReady && slot != '0)
            slot <= slot - 1'b1;
      end
   end

endmodule

// File: tb/tb_block_memory_retrieval.sv
// Directed bench for block_memory_retrieval with registered-read
// memory models and a beat scoreboard.

module tb_block_memory_retrieval;

   logic        clock = 1'b0;
   logic        reset;
   logic        storageReady;
   logic        requestValid;
   logic        requestReady;
   logic [11:0] requestSSID;
   logic [7:0]  hnmAddress;
   logic [15:0] hnmData;
   logic [11:0] hcmAddress;
   logic [10:0] hcmData;
   logic [7:0]  hlmAddress;
   logic [55:0] hlmData;
   logic        hitValid;
   logic        hitReady;
   logic [7:0]  hitInfo;
   logic        hitLast;
   logic        hitEmpty;

   logic [15:0] hnmMem [256];
   logic [10:0] hcmMem [4096];
   logic [55:0] hlmMem [256];

   // {empty, last, info}
   logic [9:0] sb [$];

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   block_memory_retrieval dut (
      .clock       (clock),
      .reset       (reset),
      .storageReady(storageReady),
      .requestValid(requestValid),
      .requestReady(requestReady),
      .requestSSID (requestSSID),
      .hnmAddress  (hnmAddress),
      .hnmData     (hnmData),
      .hcmAddress  (hcmAddress),
      .hcmData     (hcmData),
      .hlmAddress  (hlmAddress),
      .hlmData     (hlmData),
      .hitValid    (hitValid),
      .hitReady    (hitReady),
      .hitInfo     (hitInfo),
      .hitLast     (hitLast),
      .hitEmpty    (hitEmpty)
   );

   always @(posedge clock) begin
      hnmData <= hnmMem[hnmAddress];
      hcmData <= hcmMem[hcmAddress];
      hlmData <= hlmMem[hlmAddress];
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && hitValid && hitReady) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", {54'd0, hitEmpty, hitLast, hitInfo},
                  64'h3ff_0000);
         end else begin
            check("beat", {54'd0, hitEmpty, hitLast, hitInfo},
                  {54'd0, sb.pop_front()});
         end
      end
   end

   task automatic sendReq(input logic [11:0] ssid);
      requestValid = 1'b1;
      requestSSID  = ssid;
      @(negedge clock);
      check("req_ready", {63'd0, requestReady}, 64'd1);
      @(posedge clock); #1;
      requestValid = 1'b0;
   endtask

   task automatic firstBeat(input string tag, input int lat);
      int c = 1;
      while (1) begin
         @(negedge clock);
         if (hitValid || c > 20) break;
         @(posedge clock); #1;
         c++;
      end
      check(tag, 64'(c), 64'(lat));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (sb.size() == 0) break;
      end
      check(tag, 64'(sb.size()), 64'd0);
   endtask

   task automatic pushHits(input logic [55:0] w, input int n);
      logic [55:0] t;
      t = w;
      for (int k = n - 1; k >= 0; k--)
         sb.push_back({1'b0, k == 0, t[k*8 +: 8]});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         hnmMem[i] = '0;
         hlmMem[i] = '0;
      end
      for (int i = 0; i < 4096; i++) hcmMem[i] = '0;
      reset        = 1'b1;
      storageReady = 1'b1;
      requestValid = 1'b0;
      requestSSID  = '0;
      hitReady     = 1'b1;

      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_hitValid", {63'd0, hitValid}, 64'd0);
      check("rst_hitLast", {63'd0, hitLast}, 64'd0);
      check("rst_hitEmpty", {63'd0, hitEmpty}, 64'd0);
      check("rst_hitInfo", {56'd0, hitInfo}, 64'd0);
      check("rst_reqReady", {63'd0, requestReady}, 64'd0);
      check("rst_addr", {36'd0, hnmAddress, hcmAddress, hlmAddress},
            64'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // miss: HNM bit clear
      sb.push_back({1'b1, 1'b1, 8'h00});
      sendReq(12'h123);
      firstBeat("miss_latency", 3);
      drain("miss_drain");

      // hit, three words
      hnmMem[8'h12]   = 16'h0008;
      hcmMem[12'h123] = {8'h05, 3'd3};
      hlmMem[8'h05]   = 56'hAABBCC;
      pushHits(56'hAABBCC, 3);
      sendReq(12'h123);
      firstBeat("hit_latency", 5);
      check("hlm_address", {56'd0, hlmAddress}, 64'h05);
      drain("hit_drain");

      // stall on second beat
      pushHits(56'hAABBCC, 3);
      sendReq(12'h123);
      firstBeat("stall_latency", 5);
      @(posedge clock); #1;
      hitReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("stall_hold", {54'd0, hitValid, hitLast, hitInfo},
               {54'd0, 10'h2BB});
      end
      @(posedge clock); #1;
      hitReady = 1'b1;
      drain("stall_drain");

      // storage busy blocks accept
      storageReady = 1'b0;
      requestValid = 1'b1;
      requestSSID  = 12'h123;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check("busy_reqReady", {63'd0, requestReady}, 64'd0);
         check("busy_hitValid", {63'd0, hitValid}, 64'd0);
         @(posedge clock); #1;
      end
      requestValid = 1'b0;
      storageReady = 1'b1;

      // abort during READ
      sb.push_back({1'b1, 1'b1, 8'h00});
      sendReq(12'h123);
      storageReady = 1'b0;
      firstBeat("abort_latency", 2);
      @(posedge clock); #1;
      storageReady = 1'b1;
      drain("abort_drain");

      // full slot word, count 7
      hnmMem[8'hAB]   = 16'h1000;
      hcmMem[12'hABC] = {8'h01, 3'd7};
      hlmMem[8'h01]   = 56'h01020304050607;
      pushHits(56'h01020304050607, 7);
      sendReq(12'hABC);
      firstBeat("full_latency", 5);
      drain("full_drain");

      // reset mid-EMIT
      pushHits(56'hAABBCC, 3);
      sendReq(12'h123);
      firstBeat("rstmid_latency", 5);
      @(posedge clock); #1;
      reset = 1'b1;
      sb.delete();
      @(posedge clock); #1;
      @(negedge clock);
      check("rstmid_hitValid", {63'd0, hitValid}, 64'd0);
      check("rstmid_reqReady", {63'd0, requestReady}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("rstmid_reqReady_rel", {63'd0, requestReady}, 64'd1);
      check("rstmid_idle", {63'd0, hitValid}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
